// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for the inter-stage pipeline register.
package pipe_pkg;

    localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One data+valid holding register with load and clear enables; clear wins over load.
module pipe_slot #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data,
    output logic         o_valid
);

    logic [W-1:0] r_data;
    logic         r_valid;

    // Clearing drops only the valid bit; the data (and hence the PC) keeps its last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register between two stages, valid/ready handshake,
// flush to bubble, optional two-entry skid buffer giving a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          INST_W   = 32,
    parameter int unsigned          PC_W     = 32,
    parameter int unsigned          SKID     = 1,
    parameter logic [INST_W-1:0]    NOP_INST = INST_W'(PIPE_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy
);

    localparam int unsigned DW = INST_W + PC_W;

    pipe_state_t r_state;
    pipe_state_t w_state_nxt;

    logic [DW-1:0] w_in_data;
    logic [DW-1:0] w_main_d;
    logic [DW-1:0] w_main_q;
    logic [DW-1:0] w_skid_q;
    logic          w_main_valid;
    logic          w_skid_valid;
    logic          w_in_ready;
    logic          w_in_fire;
    logic          w_out_fire;
    logic          w_main_load;
    logic          w_main_clr;
    logic          w_skid_load;
    logic          w_skid_clr;

    assign w_in_data  = {in_inst, in_pc};
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = w_main_valid & out_ready;
    // The skid entry is only ever occupied in FULL, so it is always the next head.
    assign w_main_d   = w_skid_valid ? w_skid_q : w_in_data;

    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_clr  = 1'b1;
                    end else if (w_in_fire && (SKID != 0)) begin
                        w_state_nxt = ST_FULL;
                        w_skid_load = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_load = 1'b1;
                        w_skid_clr  = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    pipe_slot #(.W(DW)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clr),
        .i_data  (w_main_d),
        .o_data  (w_main_q),
        .o_valid (w_main_valid)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;

            pipe_slot #(.W(DW)) u_skid (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clr),
                .i_data  (w_in_data),
                .o_data  (w_skid_q),
                .o_valid (w_skid_valid)
            );

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != ST_FULL);
                end
            end

            assign w_in_ready = r_in_ready & rst_n;
        end else begin : g_noskid
            assign w_skid_q     = '0;
            assign w_skid_valid = 1'b0;
            assign w_in_ready   = rst_n & (~w_main_valid | out_ready);
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_main_valid;
    assign out_inst  = w_main_valid ? w_main_q[DW-1:PC_W] : NOP_INST;
    assign out_pc    = w_main_q[PC_W-1:0];
    assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance checked every cycle
// against a FIFO-of-entries reference model, directed scenarios then random traffic.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_inst   [2];
    logic [31:0] in_pc     [2];
    logic        flush     [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_inst  [2];
    logic [31:0] out_pc    [2];
    logic [1:0]  occupancy [2];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: per instance an ordered list of held entries (head first).
    logic [31:0] m_inst [2][2];
    logic [31:0] m_pc   [2][2];
    int unsigned m_cnt  [2];
    logic [31:0] m_last_pc [2];
    logic [31:0] src_pc [2];
    logic        chk_en = 1'b0;

    logic        hold     [2];
    logic [31:0] sav_inst [2];
    logic [31:0] sav_pc   [2];

    always #5 clk = ~clk;

    pipe_stage_reg #(.INST_W(32), .PC_W(32), .SKID(1), .NOP_INST(NOP)) u_dut_skid (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_inst(in_inst[0]), .in_pc(in_pc[0]),
        .flush(flush[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_inst(out_inst[0]), .out_pc(out_pc[0]),
        .occupancy(occupancy[0])
    );

    pipe_stage_reg #(.INST_W(32), .PC_W(32), .SKID(0), .NOP_INST(NOP)) u_dut_noskid (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_inst(in_inst[1]), .in_pc(in_pc[1]),
        .flush(flush[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_inst(out_inst[1]), .out_pc(out_pc[1]),
        .occupancy(occupancy[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Instance 0 has the skid buffer (capacity 2, ready from occupancy only);
    // instance 1 has capacity 1 and can accept while its entry leaves.
    function automatic logic exp_ready(input int k);
        if (!rst_n) return 1'b0;
        if (k == 0) return (m_cnt[k] < 2);
        return (m_cnt[k] == 0) || out_ready[k];
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_cnt[k]     = 0;
                m_last_pc[k] = '0;
                src_pc[k]    = '0;
            end else begin
                logic fin;
                logic fout;
                fin  = in_valid[k] && exp_ready(k);
                fout = (m_cnt[k] > 0) && out_ready[k];
                if (fin) src_pc[k] = src_pc[k] + 32'd4;
                if (flush[k]) begin
                    m_cnt[k] = 0;
                end else begin
                    if (fout) begin
                        m_inst[k][0] = m_inst[k][1];
                        m_pc[k][0]   = m_pc[k][1];
                        m_cnt[k]     = m_cnt[k] - 1;
                    end
                    if (fin) begin
                        m_inst[k][m_cnt[k]] = in_inst[k];
                        m_pc[k][m_cnt[k]]   = in_pc[k];
                        m_cnt[k]            = m_cnt[k] + 1;
                    end
                end
                if (m_cnt[k] > 0) m_last_pc[k] = m_pc[k][0];
            end
        end
        if (!rst_n) chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [31:0] e_inst;
                logic [31:0] e_pc;
                e_inst = (m_cnt[k] > 0) ? m_inst[k][0] : NOP;
                e_pc   = (m_cnt[k] > 0) ? m_pc[k][0]   : m_last_pc[k];
                check($sformatf("in_ready[%0d]", k),  {63'd0, in_ready[k]},  {63'd0, exp_ready(k)});
                check($sformatf("out_valid[%0d]", k), {63'd0, out_valid[k]}, {63'd0, m_cnt[k] > 0});
                check($sformatf("out_inst[%0d]", k),  {32'd0, out_inst[k]},  {32'd0, e_inst});
                check($sformatf("out_pc[%0d]", k),    {32'd0, out_pc[k]},    {32'd0, e_pc});
                check($sformatf("occupancy[%0d]", k), {62'd0, occupancy[k]}, 64'(m_cnt[k]));
                if (hold[k]) begin
                    check($sformatf("stable_valid[%0d]", k), {63'd0, out_valid[k]}, 64'd1);
                    check($sformatf("stable_inst[%0d]", k),  {32'd0, out_inst[k]},  {32'd0, sav_inst[k]});
                    check($sformatf("stable_pc[%0d]", k),    {32'd0, out_pc[k]},    {32'd0, sav_pc[k]});
                end
                hold[k]     = rst_n && !flush[k] && out_valid[k] && !out_ready[k];
                sav_inst[k] = out_inst[k];
                sav_pc[k]   = out_pc[k];
            end
        end
    end

    task automatic step(input logic rst, input logic v, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        rst_n = rst;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = v;
            out_ready[k] = ordy;
            flush[k]     = fl;
            in_pc[k]     = src_pc[k];
            in_inst[k]   = $urandom;
        end
    endtask

    task automatic step_rand();
        @(posedge clk);
        #1;
        rst_n = ($urandom_range(0, 999) != 0);
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = ($urandom_range(0, 9) < 7);
            out_ready[k] = ($urandom_range(0, 9) < 6);
            flush[k]     = ($urandom_range(0, 99) < 3);
            in_pc[k]     = src_pc[k];
            in_inst[k]   = $urandom;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            hold[k] = 1'b0; in_valid[k] = 1'b1; out_ready[k] = 1'b0;
            flush[k] = 1'b0; in_pc[k] = '0; in_inst[k] = '0;
            m_cnt[k] = 0; m_last_pc[k] = '0; src_pc[k] = '0;
        end
        // Reset held two cycles with in_valid asserted.
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_out_inst", {32'd0, out_inst[0]}, {32'd0, 32'h0000_0013});
        check("reset_in_ready", {63'd0, in_ready[0]}, 64'd0);
        // Streaming, 8 back-to-back.
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        // Stall fill then drain.
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        // Flush while full, input offered in the same cycle.
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        // Flush with an accepted input in the same cycle.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0);
        // out_ready toggled against continuous input.
        repeat (4) begin
            step(1'b1, 1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b1, 1'b0);
        end
        // Reset mid-operation.
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0);
        // Random traffic.
        repeat (10000) step_rand();
        step(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
